// File: rtl/arp_eth_rx_if.sv
// Bundles for the ARP receive path: Ethernet header + payload stream in,
// parsed ARP frame out.
interface arp_eth_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic                  hdr_valid;
  logic                  hdr_ready;
  logic [47:0]           dest_mac;
  logic [47:0]           src_mac;
  logic [15:0]           eth_type;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output hdr_valid, dest_mac, src_mac, eth_type,
    output tdata, tkeep, tvalid, tlast, tuser,
    input  hdr_ready, tready
  );

  modport slave (
    input  hdr_valid, dest_mac, src_mac, eth_type,
    input  tdata, tkeep, tvalid, tlast, tuser,
    output hdr_ready, tready
  );
endinterface

interface arp_frame_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [47:0] eth_dest_mac;
  logic [47:0] eth_src_mac;
  logic [15:0] eth_type;
  logic [15:0] arp_htype;
  logic [15:0] arp_ptype;
  logic [7:0]  arp_hlen;
  logic [7:0]  arp_plen;
  logic [15:0] arp_oper;
  logic [47:0] arp_sha;
  logic [31:0] arp_spa;
  logic [47:0] arp_tha;
  logic [31:0] arp_tpa;

  modport master (
    output frame_valid, eth_dest_mac, eth_src_mac, eth_type,
    output arp_htype, arp_ptype, arp_hlen, arp_plen, arp_oper,
    output arp_sha, arp_spa, arp_tha, arp_tpa,
    input  frame_ready
  );

  modport slave (
    input  frame_valid, eth_dest_mac, eth_src_mac, eth_type,
    input  arp_htype, arp_ptype, arp_hlen, arp_plen, arp_oper,
    input  arp_sha, arp_spa, arp_tha, arp_tpa,
    output frame_ready
  );
endinterface

// File: rtl/arp_eth_rx.sv
// ARP receive parser: captures the 28-byte ARP body from the Ethernet payload
// stream, drops trailing padding, and presents the fields as one parallel frame.
module arp_eth_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic         clk,
  input  logic         rst,
  arp_eth_rx_if.slave  s_eth,
  arp_frame_if.master  m_frame,
  output logic         busy,
  output logic         error_header_early_termination,
  output logic         error_invalid_header
);
  localparam int HDR_BYTES   = 28;
  localparam int CYCLE_COUNT = (HDR_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int PTR_WIDTH   = (CYCLE_COUNT > 1) ? $clog2(CYCLE_COUNT) : 1;
  localparam logic [PTR_WIDTH-1:0] LAST_BEAT = PTR_WIDTH'(CYCLE_COUNT - 1);

  if (DATA_WIDTH != KEEP_WIDTH * 8) begin : g_width_check
    $error("arp_eth_rx: DATA_WIDTH must equal 8*KEEP_WIDTH");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_READ_HEADER, ST_DROP} state_t;

  state_t                          state_q, state_d;
  logic [PTR_WIDTH-1:0]            ptr_q, ptr_d;
  logic                            hdr_ready_q, hdr_ready_d;
  logic                            tready_q, tready_d;
  logic                            frame_valid_q, frame_valid_d;
  logic                            busy_q, busy_d;
  logic                            err_early_q, err_early_d;
  logic                            err_hdr_q, err_hdr_d;
  logic [47:0]                     dest_mac_q, dest_mac_d;
  logic [47:0]                     src_mac_q, src_mac_d;
  logic [15:0]                     eth_type_q, eth_type_d;
  logic [HDR_BYTES-1:0][7:0]       arp_bytes_q, arp_bytes_d;

  logic                  beat_fire;
  logic                  byte_we;
  logic                  finish;
  logic                  header_ok;
  logic [KEEP_WIDTH-1:0] keep_eff;

  assign keep_eff  = KEEP_ENABLE ? s_eth.tkeep : '1;
  assign beat_fire = s_eth.tvalid && tready_q;
  assign byte_we   = beat_fire && (state_q == ST_READ_HEADER);

  // Each ARP byte has a fixed (beat, lane) home, so capture is a constant-index mux.
  genvar gi;
  for (gi = 0; gi < HDR_BYTES; gi++) begin : g_byte
    localparam int BEAT = gi / KEEP_WIDTH;
    localparam int LANE = gi % KEEP_WIDTH;
    assign arp_bytes_d[gi] = (byte_we && (ptr_q == PTR_WIDTH'(BEAT)) && keep_eff[LANE])
                           ? s_eth.tdata[LANE*8 +: 8] : arp_bytes_q[gi];
  end

  // Checked on the next-state bytes so a frame ending on the last header beat is judged correctly.
  assign header_ok = ({arp_bytes_d[0], arp_bytes_d[1]} == 16'h0001) &&
                     ({arp_bytes_d[2], arp_bytes_d[3]} == 16'h0800) &&
                     (arp_bytes_d[4] == 8'd6) &&
                     (arp_bytes_d[5] == 8'd4);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    frame_valid_d = frame_valid_q;
    err_early_d   = 1'b0;
    err_hdr_d     = 1'b0;
    dest_mac_d    = dest_mac_q;
    src_mac_d     = src_mac_q;
    eth_type_d    = eth_type_q;
    finish        = 1'b0;

    if (frame_valid_q && m_frame.frame_ready) begin
      frame_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_eth.hdr_valid && hdr_ready_q) begin
          dest_mac_d = s_eth.dest_mac;
          src_mac_d  = s_eth.src_mac;
          eth_type_d = s_eth.eth_type;
          ptr_d      = '0;
          state_d    = ST_READ_HEADER;
        end
      end
      ST_READ_HEADER: begin
        if (beat_fire) begin
          if (ptr_q == LAST_BEAT) begin
            if (s_eth.tlast) begin
              finish = 1'b1;
            end else begin
              state_d = ST_DROP;
            end
          end else if (s_eth.tlast) begin
            err_early_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            ptr_d = ptr_q + PTR_WIDTH'(1);
          end
        end
      end
      ST_DROP: begin
        if (beat_fire && s_eth.tlast) begin
          finish = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d = ST_IDLE;
      if (!s_eth.tuser) begin
        if (header_ok) begin
          frame_valid_d = 1'b1;
        end else begin
          err_hdr_d = 1'b1;
        end
      end
    end

    // Registered from next state, so a header can never be taken in the frame-handshake cycle.
    hdr_ready_d = (state_d == ST_IDLE) && !frame_valid_d;
    tready_d    = (state_d != ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      hdr_ready_q   <= 1'b0;
      tready_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_early_q   <= 1'b0;
      err_hdr_q     <= 1'b0;
      dest_mac_q    <= '0;
      src_mac_q     <= '0;
      eth_type_q    <= '0;
      arp_bytes_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hdr_ready_q   <= hdr_ready_d;
      tready_q      <= tready_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      err_early_q   <= err_early_d;
      err_hdr_q     <= err_hdr_d;
      dest_mac_q    <= dest_mac_d;
      src_mac_q     <= src_mac_d;
      eth_type_q    <= eth_type_d;
      arp_bytes_q   <= arp_bytes_d;
    end
  end

  assign s_eth.hdr_ready = hdr_ready_q;
  assign s_eth.tready    = tready_q;

  assign busy                           = busy_q;
  assign error_header_early_termination = err_early_q;
  assign error_invalid_header           = err_hdr_q;

  assign m_frame.frame_valid  = frame_valid_q;
  assign m_frame.eth_dest_mac = dest_mac_q;
  assign m_frame.eth_src_mac  = src_mac_q;
  assign m_frame.eth_type     = eth_type_q;
  assign m_frame.arp_htype    = {arp_bytes_q[0], arp_bytes_q[1]};
  assign m_frame.arp_ptype    = {arp_bytes_q[2], arp_bytes_q[3]};
  assign m_frame.arp_hlen     = arp_bytes_q[4];
  assign m_frame.arp_plen     = arp_bytes_q[5];
  assign m_frame.arp_oper     = {arp_bytes_q[6], arp_bytes_q[7]};
  assign m_frame.arp_sha      = {arp_bytes_q[8], arp_bytes_q[9], arp_bytes_q[10],
                                 arp_bytes_q[11], arp_bytes_q[12], arp_bytes_q[13]};
  assign m_frame.arp_spa      = {arp_bytes_q[14], arp_bytes_q[15], arp_bytes_q[16], arp_bytes_q[17]};
  assign m_frame.arp_tha      = {arp_bytes_q[18], arp_bytes_q[19], arp_bytes_q[20],
                                 arp_bytes_q[21], arp_bytes_q[22], arp_bytes_q[23]};
  assign m_frame.arp_tpa      = {arp_bytes_q[24], arp_bytes_q[25], arp_bytes_q[26], arp_bytes_q[27]};
endmodule

// File: tb/tb_arp_eth_rx.sv
// Bench for arp_eth_rx: 8-bit and 64-bit instances driven with directed and
// random ARP frames, checked against a byte-level model of the ARP body.
module tb_arp_eth_rx;
  typedef struct packed {
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_t;

  localparam int K_FRAME = 0, K_EARLY = 1, K_HDR = 2, K_NONE = 3;

  logic clk, rst;
  logic busy8, eet8, eih8, busy64, eet64, eih64;

  arp_eth_rx_if #(.DATA_WIDTH(8))  e8 ();
  arp_eth_rx_if #(.DATA_WIDTH(64)) e64 ();
  arp_frame_if f8 ();
  arp_frame_if f64 ();

  arp_eth_rx #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .s_eth(e8), .m_frame(f8), .busy(busy8),
    .error_header_early_termination(eet8), .error_invalid_header(eih8));
  arp_eth_rx #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .s_eth(e64), .m_frame(f64), .busy(busy64),
    .error_header_early_termination(eet64), .error_invalid_header(eih64));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0]   shadow [2][28];     // model of the stored ARP body per instance
  logic [111:0] hdr_model [2];
  logic o_valid, o_early, o_ihdr, o_busy, o_hready, o_tready;
  arp_t o_frame, last_frame;
  logic [111:0] o_eth;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      hdr_model[s] = '0;
      for (int i = 0; i < 28; i++) shadow[s][i] = 8'h00;
    end
  endtask

  function automatic arp_t parse_shadow(input int s);
    logic [223:0] v;
    for (int i = 0; i < 28; i++) v[223-8*i -: 8] = shadow[s][i];
    return arp_t'(v);
  endfunction

  task automatic set_hdr(input int w, input logic v, input logic [47:0] d, input logic [47:0] s,
                         input logic [15:0] t);
    if (w == 8) begin
      e8.hdr_valid = v; e8.dest_mac = d; e8.src_mac = s; e8.eth_type = t;
    end else begin
      e64.hdr_valid = v; e64.dest_mac = d; e64.src_mac = s; e64.eth_type = t;
    end
  endtask

  task automatic set_beat(input int w, input logic v, input logic [63:0] d, input logic [7:0] k,
                          input logic last, input logic user);
    if (w == 8) begin
      e8.tvalid = v; e8.tdata = d[7:0]; e8.tkeep = k[0]; e8.tlast = last; e8.tuser = user;
    end else begin
      e64.tvalid = v; e64.tdata = d; e64.tkeep = k; e64.tlast = last; e64.tuser = user;
    end
  endtask

  task automatic set_ready(input int w, input logic v);
    if (w == 8) f8.frame_ready = v;
    else        f64.frame_ready = v;
  endtask

  task automatic sample(input int w);
    if (w == 8) begin
      o_valid = f8.frame_valid; o_early = eet8; o_ihdr = eih8; o_busy = busy8;
      o_hready = e8.hdr_ready; o_tready = e8.tready;
      o_eth = {f8.eth_dest_mac, f8.eth_src_mac, f8.eth_type};
      o_frame = {f8.arp_htype, f8.arp_ptype, f8.arp_hlen, f8.arp_plen, f8.arp_oper,
                 f8.arp_sha, f8.arp_spa, f8.arp_tha, f8.arp_tpa};
    end else begin
      o_valid = f64.frame_valid; o_early = eet64; o_ihdr = eih64; o_busy = busy64;
      o_hready = e64.hdr_ready; o_tready = e64.tready;
      o_eth = {f64.eth_dest_mac, f64.eth_src_mac, f64.eth_type};
      o_frame = {f64.arp_htype, f64.arp_ptype, f64.arp_hlen, f64.arp_plen, f64.arp_oper,
                 f64.arp_sha, f64.arp_spa, f64.arp_tha, f64.arp_tpa};
    end
  endtask

  task automatic check_idle_zero(input string pfx);
    check_val({pfx, "_hdr_ready"}, 64'(o_hready), 64'd0);
    check_val({pfx, "_tready"},    64'(o_tready), 64'd0);
    check_val({pfx, "_valid"},     64'(o_valid),  64'd0);
    check_val({pfx, "_busy"},      64'(o_busy),   64'd0);
    check_val({pfx, "_errs"},      64'({o_early, o_ihdr}), 64'd0);
    check_val({pfx, "_sha"},       64'(o_frame.sha), 64'd0);
    check_val({pfx, "_dest_mac"},  64'(o_eth[111:64]), 64'd0);
  endtask

  // Sends header then payload; returns at the negedge right after the tlast beat is taken.
  task automatic send_frame(input int w, input logic [47:0] dmac, input logic [47:0] smac,
                            input arp_t a, input int len, input bit user, input bit clear_keep,
                            input int abort_after, output bit early);
    int kw, s, nb, n;
    logic [223:0] v;
    logic [7:0] pl [$];
    kw = w / 8; s = (w == 64) ? 1 : 0; nb = (len + kw - 1) / kw; early = 1'b0; v = a;
    for (int i = 0; i < len; i++) pl.push_back(i < 28 ? v[223-8*i -: 8] : 8'($urandom));
    set_hdr(w, 1'b1, dmac, smac, 16'h0806);
    n = 0; sample(w);
    while (!o_hready && n < 100) begin @(negedge clk); sample(w); n++; end
    if (!o_hready) begin
      check_val("hdr_accept_timeout", 64'd0, 64'd1);
      set_hdr(w, 1'b0, dmac, smac, 16'h0806);
      return;
    end
    @(negedge clk);
    set_hdr(w, 1'b0, dmac, smac, 16'h0806);
    hdr_model[s] = {dmac, smac, 16'h0806};
    sample(w); check_val("busy_in_frame", 64'(o_busy), 64'd1);
    for (int b = 0; b < nb; b++) begin
      logic [63:0] d;
      logic [7:0] k;
      if (b == abort_after) begin
        set_beat(w, 1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        set_beat(w, 1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
      end
      d = {$urandom, $urandom}; k = 8'd0;
      for (int l = 0; l < kw; l++) begin
        if (b*kw + l < len) begin d[8*l +: 8] = pl[b*kw + l]; k[l] = 1'b1; end
      end
      if (clear_keep && w == 64 && b < nb - 1) k[$urandom_range(0, 7)] = 1'b0;
      if (clear_keep && w == 8) k[0] = 1'($urandom_range(0, 1));
      set_beat(w, 1'b1, d, k, b == nb - 1, (b == nb - 1) ? user : 1'($urandom_range(0, 1)));
      n = 0; sample(w);
      while (!o_tready && n < 20) begin @(negedge clk); sample(w); n++; end
      if (!o_tready) begin
        check_val("tready_timeout", 64'd0, 64'd1);
        set_beat(w, 1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
        return;
      end
      @(negedge clk);
      for (int l = 0; l < kw; l++) begin
        if (b*kw + l < 28 && (w == 8 || k[l])) shadow[s][b*kw + l] = d[8*l +: 8];
      end
    end
    set_beat(w, 1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
    early = nb < (28 + kw - 1) / kw;
  endtask

  task automatic check_result(input int w, input int kind, input int hold);
    int s;
    arp_t e;
    s = (w == 64) ? 1 : 0;
    e = parse_shadow(s);
    sample(w);
    check_val("valid_latency",   64'(o_valid), 64'(kind == K_FRAME));
    check_val("err_early_pulse", 64'(o_early), 64'(kind == K_EARLY));
    check_val("err_hdr_pulse",   64'(o_ihdr),  64'(kind == K_HDR));
    check_val("busy_after_last", 64'(o_busy),  64'd0);
    if (kind == K_FRAME) begin
      check_val("dest_mac", 64'(o_eth[111:64]), 64'(hdr_model[s][111:64]));
      check_val("src_mac",  64'(o_eth[63:16]),  64'(hdr_model[s][63:16]));
      check_val("eth_type", 64'(o_eth[15:0]),   64'(hdr_model[s][15:0]));
      check_val("htype", 64'(o_frame.htype), 64'(e.htype));
      check_val("ptype", 64'(o_frame.ptype), 64'(e.ptype));
      check_val("hlen",  64'(o_frame.hlen),  64'(e.hlen));
      check_val("plen",  64'(o_frame.plen),  64'(e.plen));
      check_val("oper",  64'(o_frame.oper),  64'(e.oper));
      check_val("sha",   64'(o_frame.sha),   64'(e.sha));
      check_val("spa",   64'(o_frame.spa),   64'(e.spa));
      check_val("tha",   64'(o_frame.tha),   64'(e.tha));
      check_val("tpa",   64'(o_frame.tpa),   64'(e.tpa));
      last_frame = o_frame;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); sample(w);
        check_val("hold_valid",     64'(o_valid),     64'd1);
        check_val("hold_hdr_ready", 64'(o_hready),    64'd0);
        check_val("hold_sha",       64'(o_frame.sha), 64'(e.sha));
        check_val("hold_tpa",       64'(o_frame.tpa), 64'(e.tpa));
      end
    end
    set_ready(w, 1'b1);
    @(negedge clk); sample(w);
    check_val("valid_after_hs",   64'(o_valid),  64'd0);
    check_val("pulse_len",        64'({o_early, o_ihdr}), 64'd0);
    check_val("hdr_ready_again",  64'(o_hready), 64'd1);
  endtask

  task automatic run_case(input string name, input int w, input arp_t a, input int len,
                          input bit user, input bit clear_keep, input int hold);
    logic [63:0] r;
    bit early;
    int kind;
    arp_t e;
    string kn;
    r = {$urandom, $urandom};
    set_ready(w, hold == 0);
    send_frame(w, r[47:0], {r[23:0], r[63:40]}, a, len, user, clear_keep, -1, early);
    e = parse_shadow((w == 64) ? 1 : 0);
    if (early)      kind = K_EARLY;
    else if (user)  kind = K_NONE;
    else if (e.htype == 16'h0001 && e.ptype == 16'h0800 && e.hlen == 8'd6 && e.plen == 8'd4)
                    kind = K_FRAME;
    else            kind = K_HDR;
    kn = (kind == K_FRAME) ? "frame" : (kind == K_EARLY) ? "early_err" :
         (kind == K_HDR) ? "hdr_err" : "silent_drop";
    $display("tb: %s w=%0d len=%0d tuser=%0d hold=%0d expect=%s", name, w, len, user, hold, kn);
    check_result(w, kind, hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    arp_t req, a;
    int w, kind, len, hold;
    bit user, early;
    logic [63:0] r;
    clk = 1'b0; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? 8 : 64;
      set_hdr(w, 1'b0, 48'd0, 48'd0, 16'd0);
      set_beat(w, 1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
      set_ready(w, 1'b1);
    end
    clear_model();
    repeat (3) @(negedge clk);
    sample(8);  check_idle_zero("rst8");
    sample(64); check_idle_zero("rst64");
    rst = 1'b0;

    req = {16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001, 48'h020000000001,
           32'hC0A80164, 48'h000000000000, 32'hC0A80101};
    run_case("arp_req_8b", 8, req, 46, 1'b0, 1'b0, 0);
    check_val("req8_oper", 64'(last_frame.oper), 64'h1);
    check_val("req8_sha",  64'(last_frame.sha),  64'h020000000001);
    check_val("req8_spa",  64'(last_frame.spa),  64'hC0A80164);
    check_val("req8_tpa",  64'(last_frame.tpa),  64'hC0A80101);
    run_case("arp_req_64b_hold", 64, req, 28, 1'b0, 1'b0, 10);
    check_val("req64_sha", 64'(last_frame.sha), 64'h020000000001);
    check_val("req64_tpa", 64'(last_frame.tpa), 64'hC0A80101);
    run_case("early_byte20", 8, req, 21, 1'b0, 1'b0, 0);
    a = req; a.hlen = 8'd8;
    run_case("bad_hlen", 8, a, 40, 1'b0, 1'b0, 0);
    a = req; a.oper = 16'h0002; a.tha = 48'h0A0B0C0D0E0F;
    run_case("after_bad_hlen", 8, a, 28, 1'b0, 1'b0, 0);
    run_case("tuser_drop", 64, req, 60, 1'b1, 1'b0, 0);

    set_ready(8, 1'b1);
    send_frame(8, 48'h111111111111, 48'h222222222222, req, 46, 1'b0, 1'b0, 10, early);
    $display("tb: reset_mid_header w=8 beats_before_reset=10");
    #2 rst = 1'b1;
    #1 sample(8);
    check_idle_zero("async_rst");
    check_val("async_rst_spa", 64'(o_frame.spa), 64'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    run_case("after_reset", 8, a, 46, 1'b0, 1'b0, 0);

    for (int t = 0; t < 24; t++) begin
      w = ($urandom_range(0, 1) == 1) ? 64 : 8;
      kind = $urandom_range(0, 9);
      r = {$urandom, $urandom};
      a = {16'h0001, 16'h0800, 8'd6, 8'd4, 16'($urandom_range(1, 2)), r[47:0],
           32'($urandom), {r[15:0], 32'($urandom)}, 32'($urandom)};
      len = 28 + $urandom_range(0, 20);
      user = 1'b0;
      hold = $urandom_range(0, 3);
      if (kind == 7) begin
        case ($urandom_range(0, 3))
          0: a.hlen = 8'd8;
          1: a.plen = 8'd6;
          2: a.htype = 16'h0002;
          default: a.ptype = 16'h86DD;
        endcase
      end else if (kind == 8) begin
        user = 1'b1;
      end else if (kind == 9) begin
        len = $urandom_range(1, 27);
      end
      run_case("random", w, a, len, user, 1'($urandom_range(0, 1)), hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
